// File: rtl/orpsoc_jtag_top.sv
// Simulation SoC top: word RAM, reset register and an oversampled JTAG TAP for host RAM access.
// Optional macro ORPSOC_MEM_AUTOINC_EN: post-increment the RAM address after MEMWRITE/MEMREAD updates.
module orpsoc_jtag_top #(
  parameter logic [31:0] MEM_SIZE                 = 32'h02000000,
  parameter string       pipeline                 = "CAPPUCCINO",
  parameter string       feature_immu             = "ENABLED",
  parameter string       feature_dmmu             = "ENABLED",
  parameter string       feature_instructioncache = "ENABLED",
  parameter string       feature_datacache        = "ENABLED",
  parameter string       feature_debugunit        = "ENABLED",
  parameter string       feature_cmov             = "ENABLED",
  parameter string       feature_ext              = "ENABLED",
  parameter int          option_rf_num_shadow_gpr = 0,
  parameter logic [31:0] IDCODE                   = 32'h14951185
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic tms_pad_i,
  input  logic tck_pad_i,
  input  logic tdi_pad_i,
  output logic tdo_pad_o
);

  localparam int MEM_WORDS = int'(MEM_SIZE >> 2);
  localparam int AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [3:0] IR_IDCODE   = 4'h1;
  localparam logic [3:0] IR_MEMADDR  = 4'h8;
  localparam logic [3:0] IR_MEMWRITE = 4'h9;
  localparam logic [3:0] IR_MEMREAD  = 4'hA;
  localparam logic [3:0] IR_CONFIG   = 4'hB;

  localparam logic [7:0]  SHADOW      = 8'(option_rf_num_shadow_gpr);
  localparam logic [31:0] CONFIG_WORD = {MEM_SIZE[31:16], SHADOW,
                                         pipeline == "CAPPUCCINO",
                                         feature_ext == "ENABLED",
                                         feature_cmov == "ENABLED",
                                         feature_debugunit == "ENABLED",
                                         feature_datacache == "ENABLED",
                                         feature_instructioncache == "ENABLED",
                                         feature_dmmu == "ENABLED",
                                         feature_immu == "ENABLED"};

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
    SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
  } tap_state_t;

  tap_state_t tap_state, tap_next;

  logic        wb_rst;
  logic        unused_ok;
  logic [1:0]  tck_sync, tms_sync, tdi_sync;
  logic        tck_prev;
  logic        tck_rise, tck_fall, tms, tdi;
  logic        upd_dr_pulse, upd_ir_pulse;
  logic [3:0]  ir, ir_shift;
  logic [31:0] dr_shift;
  logic        bypass_reg;
  logic        bypass_sel;
  logic [31:0] addr;
  logic        in_range;
  logic [AW-1:0] word_idx;
  logic [31:0] rd_data;
  logic [31:0] capture_value;
  logic [31:0] mem [0:MEM_WORDS-1];

  // Reset distribution; observed hierarchically as the init-done indicator.
  always_ff @(posedge wb_clk_i) wb_rst <= wb_rst_i;
  assign unused_ok = wb_rst;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_prev <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[0], tck_pad_i};
      tms_sync <= {tms_sync[0], tms_pad_i};
      tdi_sync <= {tdi_sync[0], tdi_pad_i};
      tck_prev <= tck_sync[1];
    end
  end

  assign tck_rise = tck_sync[1] & ~tck_prev;
  assign tck_fall = ~tck_sync[1] & tck_prev;
  assign tms      = tms_sync[1];
  assign tdi      = tdi_sync[1];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) tap_state <= TLR;
    else if (tck_rise) tap_state <= tap_next;
  end

  always_comb begin
    tap_next = tap_state;
    case (tap_state)
      TLR:      tap_next = tms ? TLR      : RTI;
      RTI:      tap_next = tms ? SEL_DR   : RTI;
      SEL_DR:   tap_next = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   tap_next = tms ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: tap_next = tms ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: tap_next = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: tap_next = tms ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: tap_next = tms ? UPD_DR   : SHIFT_DR;
      UPD_DR:   tap_next = tms ? SEL_DR   : RTI;
      SEL_IR:   tap_next = tms ? TLR      : CAP_IR;
      CAP_IR:   tap_next = tms ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: tap_next = tms ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: tap_next = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: tap_next = tms ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: tap_next = tms ? UPD_IR   : SHIFT_IR;
      UPD_IR:   tap_next = tms ? SEL_DR   : RTI;
      default:  tap_next = TLR;
    endcase
  end

  // Update actions run one system clock after the TCK edge that enters Update-xR.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      upd_dr_pulse <= 1'b0;
      upd_ir_pulse <= 1'b0;
    end else begin
      upd_dr_pulse <= tck_rise && (tap_next == UPD_DR);
      upd_ir_pulse <= tck_rise && (tap_next == UPD_IR);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ir       <= IR_IDCODE;
      ir_shift <= '0;
    end else begin
      if (tck_rise) begin
        if (tap_state == CAP_IR) ir_shift <= 4'b0101;
        else if (tap_state == SHIFT_IR) ir_shift <= {tdi, ir_shift[3:1]};
      end
      if (tap_state == TLR) ir <= IR_IDCODE;
      else if (upd_ir_pulse) ir <= ir_shift;
    end
  end

  assign bypass_sel = !(ir inside {IR_IDCODE, IR_MEMADDR, IR_MEMWRITE, IR_MEMREAD, IR_CONFIG});
  assign in_range   = addr < MEM_SIZE;
  assign word_idx   = addr[AW+1:2];
  assign rd_data    = in_range ? mem[word_idx] : 32'h0;

  always_comb begin
    capture_value = 32'h0;
    case (ir)
      IR_IDCODE:  capture_value = IDCODE;
      IR_MEMADDR: capture_value = addr;
      IR_MEMREAD: capture_value = rd_data;
      IR_CONFIG:  capture_value = CONFIG_WORD;
      default:    capture_value = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dr_shift   <= '0;
      bypass_reg <= 1'b0;
      addr       <= '0;
    end else begin
      if (tck_rise) begin
        if (tap_state == CAP_DR) begin
          dr_shift   <= capture_value;
          bypass_reg <= 1'b0;
        end else if (tap_state == SHIFT_DR) begin
          if (bypass_sel) bypass_reg <= tdi;
          else dr_shift <= {tdi, dr_shift[31:1]};
        end
      end
      if (upd_dr_pulse) begin
        if (ir == IR_MEMADDR) addr <= dr_shift;
`ifdef ORPSOC_MEM_AUTOINC_EN
        else if (ir == IR_MEMWRITE || ir == IR_MEMREAD) addr <= addr + 32'd4;
`endif
      end
    end
  end

  // RAM contents survive reset; out-of-range writes are dropped.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && upd_dr_pulse && ir == IR_MEMWRITE && in_range)
      mem[word_idx] <= dr_shift;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tdo_pad_o <= 1'b0;
    end else if (tck_fall) begin
      if (tap_state == SHIFT_IR) tdo_pad_o <= ir_shift[0];
      else if (tap_state == SHIFT_DR) tdo_pad_o <= bypass_sel ? bypass_reg : dr_shift[0];
      else tdo_pad_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_orpsoc_jtag_top.sv
// Bench for orpsoc_jtag_top: drives JTAG pads as a host and checks scans against a RAM/address model.
module tb_orpsoc_jtag_top;

  localparam logic [31:0] MEM_SIZE_TB = 32'h02000000;
  localparam logic [31:0] IDCODE_TB   = 32'h14951185;
  localparam int          HALF        = 6;
`ifdef ORPSOC_MEM_AUTOINC_EN
  localparam logic [31:0] INC = 32'd4;
`else
  localparam logic [31:0] INC = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tms = 1'b1;
  logic tck = 1'b0;
  logic tdi = 1'b0;
  logic tdo;

  always #5 clk = ~clk;

  orpsoc_jtag_top dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .tms_pad_i(tms),
    .tck_pad_i(tck),
    .tdi_pad_i(tdi),
    .tdo_pad_o(tdo)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] m_mem [0:63];
  logic [31:0] m_addr;

  typedef struct {
    logic [3:0]  ir;
    logic [31:0] din;
    logic [31:0] exp;
    bit          chk;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One TCK period; TDO is sampled at the end of the low phase, before the rising edge.
  task automatic tck_cycle(input logic t_ms, input logic t_di, output logic t_do);
    @(negedge clk);
    t_do = tdo;
    tms  = t_ms;
    tdi  = t_di;
    wait_clk(1);
    tck = 1'b1;
    wait_clk(HALF);
    tck = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic tms_only(input logic v);
    logic d;
    tck_cycle(v, 1'b0, d);
  endtask

  task automatic scan_ir(input logic [3:0] v, output logic [3:0] cap);
    logic b;
    tms_only(1); tms_only(1); tms_only(0); tms_only(0);
    for (int i = 0; i < 4; i++) begin
      tck_cycle(i == 3, v[i], b);
      cap[i] = b;
    end
    tms_only(1); tms_only(0);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
    logic b;
    dout = 32'h0;
    tms_only(1); tms_only(0); tms_only(0);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], b);
      dout[i] = b;
    end
    tms_only(1); tms_only(0);
  endtask

  task automatic load_ir(input logic [3:0] v);
    logic [3:0] cap;
    scan_ir(v, cap);
    check("ir_capture", {28'h0, cap}, 32'h5);
  endtask

  task automatic op(input logic [3:0] ir, input logic [31:0] din, output logic [31:0] dout);
    load_ir(ir);
    scan_dr(32, din, dout);
  endtask

  function automatic logic [31:0] m_read();
    if (m_addr >= MEM_SIZE_TB) return 32'h0;
    return m_mem[m_addr[7:2]];
  endfunction

  task automatic m_write(input logic [31:0] d);
    if (m_addr < MEM_SIZE_TB) m_mem[m_addr[7:2]] = d;
  endtask

  initial begin
    logic [31:0] d, v, a;
    int r;

    // Reset: hold 10 clocks, check wb_rst and idle TDO.
    rst = 1'b1;
    wait_clk(10);
    check("wb_rst_during_reset", {31'h0, dut.wb_rst}, 32'h1);
    check("tdo_during_reset", {31'h0, tdo}, 32'h0);
    rst = 1'b0;
    wait_clk(2);
    check("wb_rst_after_release", {31'h0, dut.wb_rst}, 32'h0);
    wait_clk(4);
    m_addr = 32'h0;

    tms_only(0);
    check("tdo_idle_rti", {31'h0, tdo}, 32'h0);
    scan_dr(32, 32'h0, d);
    check("idcode_after_reset", d, IDCODE_TB);

    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      dut.mem[i] = v;
      m_mem[i] = v;
    end

    vecs[0]  = '{4'h1, 32'h0,        IDCODE_TB,            1'b1};
    vecs[1]  = '{4'hB, 32'h0,        32'h020000FF,         1'b1};
    vecs[2]  = '{4'h8, 32'h10,       32'h0,                1'b1};
    vecs[3]  = '{4'h9, 32'hDEADBEEF, 32'h0,                1'b0};
    vecs[4]  = '{4'h8, 32'h10,       32'h10 + INC,         1'b1};
    vecs[5]  = '{4'hA, 32'h0,        32'hDEADBEEF,         1'b1};
    vecs[6]  = '{4'h8, 32'h02000000, 32'h10 + INC,         1'b1};
    vecs[7]  = '{4'h9, 32'h12345678, 32'h0,                1'b0};
    vecs[8]  = '{4'h8, 32'h02000000, 32'h02000000 + INC,   1'b1};
    vecs[9]  = '{4'hA, 32'h0,        32'h0,                1'b1};
    vecs[10] = '{4'h8, 32'h0,        32'h02000000 + INC,   1'b1};

    for (int i = 0; i < 11; i++) begin
      op(vecs[i].ir, vecs[i].din, d);
      if (vecs[i].chk) check($sformatf("vec%0d_ir%h", i, vecs[i].ir), d, vecs[i].exp);
    end
    m_mem[4] = 32'hDEADBEEF;
    m_addr   = 32'h0;
    check("mem4_written", dut.mem[4], 32'hDEADBEEF);
    check("mem0_oor_untouched", dut.mem[0], m_mem[0]);

    // Bypass: TDO is TDI delayed by one bit, starting with the captured 0.
    load_ir(4'h7);
    v = $urandom;
    scan_dr(8, v, d);
    a = {24'h0, v[6:0], 1'b0};
    check("bypass_delay", d, a);

    // Randomized operations against the RAM/address model.
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 3);
      if (r == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 0) a = MEM_SIZE_TB + $urandom_range(0, 255);
          else a = 32'hFFFFFFF8 + $urandom_range(0, 7);
        end else begin
          a = $urandom_range(0, 127);
        end
        op(4'h8, a, d);
        check("rand_memaddr_capture", d, m_addr);
        m_addr = a;
      end else if (r == 1) begin
        v = $urandom;
        op(4'h9, v, d);
        m_write(v);
        m_addr = m_addr + INC;
      end else begin
        op(4'hA, 32'h0, d);
        check("rand_memread", d, m_read());
        m_addr = m_addr + INC;
      end
    end
    for (int i = 0; i < 64; i++) check($sformatf("mem_final[%0d]", i), dut.mem[i], m_mem[i]);

`ifdef ORPSOC_MEM_AUTOINC_EN
    op(4'h8, 32'h0, d);
    m_addr = 32'h0;
    for (int i = 1; i <= 3; i++) begin
      op(4'h9, i, d);
      m_write(i);
      m_addr = m_addr + 32'd4;
    end
    op(4'h8, 32'h0, d);
    check("burst_addr_after_writes", d, 32'd12);
    m_addr = 32'h0;
    for (int i = 1; i <= 3; i++) begin
      op(4'hA, 32'h0, d);
      check("burst_read", d, i);
      m_addr = m_addr + 32'd4;
    end
`endif

    // Reset in the middle of a MEMWRITE shift aborts the scan.
    op(4'h8, 32'h20, d);
    m_addr = 32'h20;
    load_ir(4'h9);
    tms_only(1); tms_only(0); tms_only(0);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'b1, d[0]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clk(4);
    m_addr = 32'h0;
    check("midshift_no_write", dut.mem[8], m_mem[8]);
    tms_only(0);
    scan_dr(32, 32'h0, d);
    check("midshift_tlr_idcode", d, IDCODE_TB);
    op(4'h8, 32'h0, d);
    check("midshift_addr_reset", d, 32'h0);

    // Five TMS=1 clocks from Shift-DR and from Shift-IR return to TLR.
    load_ir(4'hB);
    tms_only(1); tms_only(0); tms_only(0);
    for (int i = 0; i < 3; i++) tms_only(0);
    repeat (5) tms_only(1);
    tms_only(0);
    scan_dr(32, 32'h0, d);
    check("tms5_from_shift_dr", d, IDCODE_TB);
    tms_only(1); tms_only(1); tms_only(0); tms_only(0);
    tms_only(0); tms_only(0);
    repeat (5) tms_only(1);
    tms_only(0);
    scan_dr(32, 32'h0, d);
    check("tms5_from_shift_ir", d, IDCODE_TB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/orpsoc_jtag_top.md
Name: orpsoc_jtag_top

Overview:
- Simulation SoC top: single-port 32-bit word RAM, reset distribution, and an IEEE 1149.1-style JTAG TAP giving host access to RAM and a read-only configuration word.
- JTAG pads are oversampled in the system clock domain; no second clock.
- CPU feature parameters are reported through the CONFIG data register.

Parameters:
- MEM_SIZE, 32'h02000000, RAM size in bytes (multiple of 4).
- pipeline, "CAPPUCCINO", CPU pipeline name; CONFIG bit7 = 1 when "CAPPUCCINO", else 0.
- feature_immu / feature_dmmu / feature_instructioncache / feature_datacache / feature_debugunit / feature_cmov / feature_ext, "ENABLED", CONFIG bits 0..6 in that order; bit = 1 iff "ENABLED".
- option_rf_num_shadow_gpr, 0, CONFIG bits [15:8].
- IDCODE, 32'h14951185, IDCODE register value.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- tms_pad_i  in  1  JTAG TMS.
- tck_pad_i  in  1  JTAG TCK (slow, oversampled).
- tdi_pad_i  in  1  JTAG TDI.
- tdo_pad_o  out  1  JTAG TDO.

Behaviour:
- Internal wb_rst: register set to wb_rst_i each clock; readable hierarchically as the system "init done" indicator.
- RAM:
  - Array mem[0..MEM_SIZE/4-1] of 32 bits; byte address A maps to mem[A>>2].
  - Contents are not cleared by reset and may be backdoor-loaded by the bench.
- Pad sampling:
  - tck, tms and tdi each pass through 2 flops.
  - Rising TCK edge: advance the TAP FSM and shift sampled tdi.
  - Falling TCK edge: update tdo_pad_o.
  - TCK high and low phases must each last at least 4 wb_clk_i cycles.
- TAP FSM: standard 16 states (TLR, RTI, Select/Capture/Shift/Exit1/Pause/Exit2/Update for DR and IR).
  - Reset state TLR; entered on wb_rst or after 5 rising TCK with TMS=1.
- IR:
  - 4 bits; Capture-IR loads 4'b0101; shifted LSB first.
  - Update-IR latches the new value; TLR sets IR = IDCODE instruction.
- Instructions:
  - 0x1 IDCODE: 32-bit DR, capture = IDCODE.
  - 0x8 MEMADDR: 32-bit address register; capture = current addr; update = shifted value.
  - 0x9 MEMWRITE: 32-bit; update writes the shifted word to mem[addr>>2].
  - 0xA MEMREAD: 32-bit; capture loads mem[addr>>2].
  - 0xB CONFIG: 32-bit read-only.
    - [6:0] features, [7] pipeline.
    - [15:8] option_rf_num_shadow_gpr[7:0].
    - [31:16] MEM_SIZE[31:16].
  - 0xF and all others: BYPASS, a 1-bit DR that captures 0.
- DR shift: LSB first; tdi enters the MSB; bit0 is presented on TDO.
- TDO: driven with bit0 of the selected shift register on falling TCK in Shift-IR/Shift-DR; 0 in all other states.
- Address range:
  - addr >= MEM_SIZE: writes ignored, reads capture 32'h0.
  - addr bits [1:0] ignored; addr arithmetic wraps modulo 2^32.
- Timing: RAM write occurs in the wb_clk_i cycle after the rising TCK edge that enters Update-DR. Read data is captured at Capture-DR.
- Reset (wb_rst_i=1 at a clock edge): TAP=TLR, IR=0x1, addr=0, tdo_pad_o=0, wb_rst=1, edge detectors cleared.
  - Reset mid-shift aborts the scan with no RAM write.

Optional Feature:
- Macro ORPSOC_MEM_AUTOINC_EN.
- Defined: addr += 4 after each MEMWRITE Update-DR, and after each MEMREAD Update-DR. This enables burst transfer without reloading MEMADDR.
- Undefined: addr changes only via MEMADDR update or reset.

Test Plan:
- Hold wb_rst_i=1 for 10 clocks, release; after reset, shift 32 DR bits → TDO yields 0x14951185 LSB first; wb_rst reads 1 during reset, 0 two clocks after release.
- Load IR=0xB, shift DR with default parameters → 0x020000FF (bits 0..7 = 1, shadow=0, MEM_SIZE[31:16]=0x0200).
- IR=0x8 with DR 0x00000010; IR=0x9 with DR 0xDEADBEEF → mem[4]=0xDEADBEEF. IR=0xA shifts out 0xDEADBEEF (macro undefined).
- Macro defined: MEMADDR=0, three MEMWRITE scans of 1,2,3 → mem[0..2]=1,2,3, addr=12; MEMADDR=0 then three MEMREAD scans return 1,2,3.
- MEMADDR=0x02000000, MEMWRITE 0x12345678 → no RAM change; MEMREAD returns 0. IR=0x7, DR shift of 8 bits → TDO equals TDI delayed one bit, first bit 0.
- Mid Shift-DR of MEMWRITE, assert wb_rst_i one clock → no write, TAP in TLR, IR=0x1; five TMS=1 clocks from any state → TLR.
